decode_regread: RTL
===================

# decode_regread

Front-end stage for the single-cycle li/addi datapath. It accepts 16-bit instructions, decodes them, reads the 8-bit register file, and presents `ALUSrc`, `Read_Data` and `Imm_Data` to the execution/writeback stage. It holds the register file and takes the `Result` back as a writeback. A per-register pending scoreboard stalls read-after-write hazards, and a writeback bypass removes the stall when the result arrives in the same cycle.

## Interface
Parameters:
- `DATA_W`, 8: register and immediate width.
- `NREG`, 4: register count; address width is 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  16  instruction: `opcode[15:12]`, `rd[11:10]`, `rs[9:8]`, `imm[7:0]`.
- `instr_ready`  out  1  instruction accepted this cycle when high with `instr_valid`.
- `ex_valid`  out  1  operand bundle valid toward execution.
- `ex_ready`  in  1  execution consumes the bundle.
- `ALUSrc`  out  1  0 = li (operand forced to 0), 1 = addi (operand = `Read_Data`).
- `Read_Data`  out  8  value of `rs`; 0 for li.
- `Imm_Data`  out  8  `imm` field.
- `ex_rd`  out  2  destination register carried with the bundle.
- `wb_valid`  in  1  writeback strobe.
- `wb_rd`  in  2  writeback register.
- `wb_data`  in  8  writeback value (the execution `Result`).
- `illegal`  out  1  one-cycle pulse when an illegal opcode is consumed.

## Operation
Opcodes:
- 0000 = nop.
- 0001 = li (rd ← imm).
- 0010 = addi (rd ← rs + imm).
- All others are illegal.

Accept and stall:
- `stall` = opcode is addi AND `pending[rs]` AND NOT (`wb_valid` AND `wb_rd`==`rs`).
- `instr_ready` = !`rst` AND !`stall` AND (!`ex_valid` OR `ex_ready`). It is combinational from the current instruction.
- A transfer occurs on `instr_valid` AND `instr_ready`.

Per transferred instruction:
- li/addi: output registers load. `ALUSrc` = (op==addi); `Imm_Data` = `imm`; `ex_rd` = `rd`; `ex_valid` ← 1; `pending[rd]` ← 1.
- `Read_Data` for addi = `wb_data` if `wb_valid` AND `wb_rd`==`rs` (bypass), else `regs[rs]`. For li, `Read_Data` = 0.
- nop: consumed. Outputs and `ex_valid` are unaffected except by the normal `ex_ready` drain.
- illegal: consumed. `illegal` ← 1 for one cycle, no bundle issued, no scoreboard change.

Bundle drain:
- If `ex_valid` AND `ex_ready` with no new li/addi transfer, `ex_valid` ← 0.
- While `ex_valid` AND !`ex_ready`, all ex outputs hold stable.

Writeback:
- `wb_valid` writes `regs[wb_rd]` ← `wb_data` and clears `pending[wb_rd]`.
- If the same cycle issues an instruction with `rd`==`wb_rd`, the set wins and `pending` stays 1.
- A writeback to a non-pending register still writes; `pending` stays 0.

Register file:
- No register is hardwired; all are writable.
- Arithmetic is not performed here; the 8-bit add and its wrap happen downstream.

State:
- `regs[4]`, `pending[4]`, and the output bundle register (`ex_valid` plus fields).

## Timing
- Reset: `regs` = 0, `pending` = 0, `ex_valid` = 0, `ALUSrc` = 0, `Read_Data` = 0, `Imm_Data` = 0, `ex_rd` = 0, `illegal` = 0, `instr_ready` = 0 while `rst` is high.
- Latency: an instruction accepted at edge N has `ex_valid` high after edge N; one bundle per cycle at full throughput.
- Register write is visible to reads one cycle after the `wb_valid` edge. Same-cycle reads get the bypass value.
- Reset asserted mid-operation discards the in-flight bundle and clears all pending bits on that edge; a writeback in that cycle is ignored.
- A stalled addi is released in the cycle its source writeback arrives, using the bypassed data.

## Test plan
- Reset, then li r1,0x05 with `ex_ready`=1 -> next cycle `ex_valid`=1, `ALUSrc`=0, `Read_Data`=0x00, `Imm_Data`=0x05, `ex_rd`=1; `pending[1]`=1.
- li r1,0x05 followed by addi r2,r1,0x03 with no writeback -> addi stalls (`instr_ready`=0). Drive `wb_valid`, `wb_rd`=1, `wb_data`=0x05 -> addi accepted that cycle with `Read_Data`=0x05, `Imm_Data`=0x03, `ALUSrc`=1.
- `ex_ready`=0 for 3 cycles with li r3,0xAA issued -> outputs hold 0xAA/r3 and `instr_ready`=0. Raise `ex_ready` -> next instruction accepted in that cycle.
- Opcode 0xF offered -> consumed, `illegal`=1 for exactly one cycle, `ex_valid` unchanged, `pending` unchanged. Nop -> consumed, no bundle.
- Writeback r2=0x7F, then addi r0,r2,0x01 two cycles later -> `Read_Data`=0x7F from the register file, no stall.
- `rst` pulsed while `ex_valid`=1 and `pending`=4'b0110 -> after the edge `ex_valid`=0, `pending`=0, and a following addi r1 reads 0x00.

Source files
------------

// File: rtl/decode_regread.sv
// Decode and register-read front end for the li/addi datapath: holds the register file,
// tracks pending destinations, and hands an operand bundle to execution.
module decode_regread #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic              ALUSrc,
    output logic [DATA_W-1:0] Read_Data,
    output logic [DATA_W-1:0] Imm_Data,
    output logic [AW-1:0]     ex_rd,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              illegal
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LI   = 4'h1,
        OP_ADDI = 4'h2
    } opcode_e;

    logic [3:0]        op;
    logic [AW-1:0]     rd, rs;
    logic [DATA_W-1:0] imm;
    logic              is_li, is_addi, is_nop, is_ill;
    logic              bypass_hit, stall, xfer, issue;
    logic [DATA_W-1:0] src_val;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   pending_q, pending_d;
    logic              ex_valid_q, ex_valid_d;
    logic              alusrc_q, alusrc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [AW-1:0]     ex_rd_q, ex_rd_d;
    logic              illegal_q, illegal_d;

    assign op      = instr[15:12];
    assign rd      = instr[10 +: AW];
    assign rs      = instr[8 +: AW];
    assign imm     = instr[DATA_W-1:0];
    assign is_nop  = (op == OP_NOP);
    assign is_li   = (op == OP_LI);
    assign is_addi = (op == OP_ADDI);
    assign is_ill  = !(is_nop || is_li || is_addi);

    // A writeback landing this cycle on rs both releases the stall and supplies the operand.
    assign bypass_hit  = wb_valid && (wb_rd == rs);
    assign src_val     = bypass_hit ? wb_data : regs_q[rs];
    assign stall       = is_addi && pending_q[rs] && !bypass_hit;
    assign instr_ready = !rst && !stall && (!ex_valid_q || ex_ready);
    assign xfer        = instr_valid && instr_ready;
    assign issue       = xfer && (is_li || is_addi);

    always_comb begin
        pending_d  = pending_q;
        ex_valid_d = ex_valid_q;
        alusrc_d   = alusrc_q;
        rdata_d    = rdata_q;
        imm_d      = imm_q;
        ex_rd_d    = ex_rd_q;
        illegal_d  = xfer && is_ill;

        if (ex_valid_q && ex_ready)
            ex_valid_d = 1'b0;
        if (wb_valid)
            pending_d[wb_rd] = 1'b0;
        // Issue comes after the writeback clear so a same-register set wins.
        if (issue) begin
            pending_d[rd] = 1'b1;
            ex_valid_d    = 1'b1;
            alusrc_d      = is_addi;
            rdata_d       = is_addi ? src_val : '0;
            imm_d         = imm;
            ex_rd_d       = rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            pending_q  <= '0;
            ex_valid_q <= 1'b0;
            alusrc_q   <= 1'b0;
            rdata_q    <= '0;
            imm_q      <= '0;
            ex_rd_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            if (wb_valid)
                regs_q[wb_rd] <= wb_data;
            pending_q  <= pending_d;
            ex_valid_q <= ex_valid_d;
            alusrc_q   <= alusrc_d;
            rdata_q    <= rdata_d;
            imm_q      <= imm_d;
            ex_rd_q    <= ex_rd_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ALUSrc    = alusrc_q;
    assign Read_Data = rdata_q;
    assign Imm_Data  = imm_q;
    assign ex_rd     = ex_rd_q;
    assign illegal   = illegal_q;

endmodule
